// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes, hazard FSM state type and the default register address width.
package pipeline_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_detect.sv
// Forwarding source selection for one EX operand, decided while the consumer is in ID.
module fwd_detect #(
  parameter int unsigned REG_AW = pipeline_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rd_addr_EX,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] rd_addr_MEM,
  input  logic              RegWrite_MEM,
  output logic [1:0]        fwd_sel
);
  import pipeline_pkg::*;

  logic ex_match;
  logic mem_match;

  // A load in EX cannot forward; the load-use stall moves it to MEM first.
  assign ex_match  = RegWrite_EX && !MemRead_EX && (rd_addr_EX != '0) &&
                     (rs_addr == rd_addr_EX);
  assign mem_match = RegWrite_MEM && (rd_addr_MEM != '0) && (rs_addr == rd_addr_MEM);

  always_comb begin
    fwd_sel = FWD_RF;
    if (ex_match) begin
      fwd_sel = FWD_MEM;
    end else if (mem_match) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stage enables, flushes, PC redirect and registered
// forwarding selects. Optional performance counters are built with PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = pipeline_pkg::REG_AW
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr_ID,
  input  logic [REG_AW-1:0] rs2_addr_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [REG_AW-1:0] rd_addr_EX,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] rd_addr_MEM,
  input  logic              RegWrite_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic              mem_ready,
  input  logic              Branch_EX,
  input  logic              Jump_EX,
  input  logic              zero_out_EX,
  output logic              PC_en,
  output logic              IF_ID_en,
  output logic              ID_EX_en,
  output logic              EX_MEM_en,
  output logic              MEM_WB_en,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              PC_sel,
  output logic [1:0]        fwd_A_sel,
  output logic [1:0]        fwd_B_sel
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);
  import pipeline_pkg::*;

  hz_state_t state;
  hz_state_t state_nxt;

  logic       taken;
  logic       mem_busy;
  logic       lu_hit;
  logic [1:0] fwd_a_dec;
  logic [1:0] fwd_b_dec;

  assign taken    = Jump_EX | (Branch_EX & zero_out_EX);
  assign mem_busy = (MemRead_MEM | MemWrite_MEM) & ~mem_ready;
  assign lu_hit   = MemRead_EX && RegWrite_EX && (rd_addr_EX != '0) &&
                    ((rs1_used_ID && (rs1_addr_ID == rd_addr_EX)) ||
                     (rs2_used_ID && (rs2_addr_ID == rd_addr_EX)));

  fwd_detect #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_addr      (rs1_addr_ID),
    .rd_addr_EX   (rd_addr_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemRead_EX   (MemRead_EX),
    .rd_addr_MEM  (rd_addr_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .fwd_sel      (fwd_a_dec)
  );

  fwd_detect #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_addr      (rs2_addr_ID),
    .rd_addr_EX   (rd_addr_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemRead_EX   (MemRead_EX),
    .rd_addr_MEM  (rd_addr_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .fwd_sel      (fwd_b_dec)
  );

  // Outputs follow the live hazard conditions so the first cycle of a memory
  // wait or stall is covered before the FSM has registered it.
  always_comb begin
    PC_en       = 1'b1;
    IF_ID_en    = 1'b1;
    ID_EX_en    = 1'b1;
    EX_MEM_en   = 1'b1;
    MEM_WB_en   = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    PC_sel      = 1'b0;
    if (mem_busy) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (taken) begin
      PC_sel      = 1'b1;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (lu_hit) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = RUN;
    if (mem_busy) begin
      state_nxt = MEM_WAIT;
    end else if ((state == RUN) && lu_hit && !taken) begin
      state_nxt = LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fwd_A_sel <= FWD_RF;
      fwd_B_sel <= FWD_RF;
    end else begin
      state <= state_nxt;
      if (ID_EX_flush) begin
        fwd_A_sel <= FWD_RF;
        fwd_B_sel <= FWD_RF;
      end else if (ID_EX_en) begin
        fwd_A_sel <= fwd_a_dec;
        fwd_B_sel <= fwd_b_dec;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!PC_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (taken && !mem_busy && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_addr_ID, rs2_addr_ID, rd_addr_EX, rd_addr_MEM;
  logic          rs1_used_ID, rs2_used_ID, RegWrite_EX, MemRead_EX, RegWrite_MEM;
  logic          MemRead_MEM, MemWrite_MEM, mem_ready, Branch_EX, Jump_EX, zero_out_EX;
  logic          PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic          IF_ID_flush, ID_EX_flush, PC_sel;
  logic [1:0]    fwd_A_sel, fwd_B_sel;
`ifdef PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0]  m_fwd_a, m_fwd_b;
  logic [31:0] m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_addr_EX(rd_addr_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .rd_addr_MEM(rd_addr_MEM), .RegWrite_MEM(RegWrite_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .mem_ready(mem_ready),
    .Branch_EX(Branch_EX), .Jump_EX(Jump_EX), .zero_out_EX(zero_out_EX),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .PC_sel(PC_sel),
    .fwd_A_sel(fwd_A_sel), .fwd_B_sel(fwd_B_sel)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_taken();
    return Jump_EX || (Branch_EX && zero_out_EX);
  endfunction

  function automatic logic ref_busy();
    return (MemRead_MEM || MemWrite_MEM) && !mem_ready;
  endfunction

  function automatic logic ref_lu();
    if (!(MemRead_EX && RegWrite_EX) || rd_addr_EX == 0) return 1'b0;
    return (rs1_used_ID && rs1_addr_ID == rd_addr_EX) ||
           (rs2_used_ID && rs2_addr_ID == rd_addr_EX);
  endfunction

  // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, PC_sel}
  function automatic logic [7:0] ref_ctrl();
    if (ref_busy())  return 8'b00000_000;
    if (ref_taken()) return 8'b11111_111;
    if (ref_lu())    return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  // Youngest non-load producer wins, otherwise the MEM-stage producer, else regfile.
  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (RegWrite_EX && !MemRead_EX && rd_addr_EX != 0 && rs == rd_addr_EX) return 2'b01;
    if (RegWrite_MEM && rd_addr_MEM != 0 && rs == rd_addr_MEM) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ref_busy() || (!ref_taken() && ref_lu())) m_stall++;
      if (!ref_busy() && ref_taken()) m_flush++;
      if (!ref_busy()) begin
        if (ref_taken() || ref_lu()) begin
          m_fwd_a = 2'b00;
          m_fwd_b = 2'b00;
        end else begin
          m_fwd_a = ref_fwd(rs1_addr_ID);
          m_fwd_b = ref_fwd(rs2_addr_ID);
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("ctrl", {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                   IF_ID_flush, ID_EX_flush, PC_sel}, ref_ctrl());
    check("fwd_A", fwd_A_sel, m_fwd_a);
    check("fwd_B", fwd_B_sel, m_fwd_b);
`ifdef PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_events", flush_events, m_flush);
`endif
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rs1_addr_ID = '0; rs2_addr_ID = '0; rs1_used_ID = 0; rs2_used_ID = 0;
    rd_addr_EX = '0; RegWrite_EX = 0; MemRead_EX = 0;
    rd_addr_MEM = '0; RegWrite_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
    mem_ready = 1; Branch_EX = 0; Jump_EX = 0; zero_out_EX = 0;
  endtask

  initial begin
`ifdef PERF_CNT_EN
    logic [31:0] stall_before;
`endif
    idle();
    rst_n = 0;
    model_reset();
    #2;
    check("rst_fwd_A", fwd_A_sel, 2'b00);
    check("rst_fwd_B", fwd_B_sel, 2'b00);
    @(posedge clk); #1 rst_n = 1;
    cycle();

    // Load-use: lw x5 in EX, add reading x5 in ID
    RegWrite_EX = 1; MemRead_EX = 1; rd_addr_EX = 5;
    rs1_addr_ID = 5; rs1_used_ID = 1; rs2_addr_ID = 2; rs2_used_ID = 1;
    #1 check("lu_ctrl", {PC_en, IF_ID_en, ID_EX_flush, EX_MEM_en, MEM_WB_en}, 5'b00111);
    cycle();
    RegWrite_EX = 0; MemRead_EX = 0; rd_addr_EX = 0;
    RegWrite_MEM = 1; MemRead_MEM = 1; rd_addr_MEM = 5;
    #1 check("lu_release_pc_en", PC_en, 1'b1);
    cycle();
    check("lu_fwd_A", fwd_A_sel, 2'b10);
    idle();
    cycle();

    // EX forward: add x3 in EX, sub reading rs2=x3 in ID
    RegWrite_EX = 1; rd_addr_EX = 3;
    rs1_addr_ID = 1; rs2_addr_ID = 3; rs1_used_ID = 1; rs2_used_ID = 1;
    cycle();
    check("exfwd_B", fwd_B_sel, 2'b01);
    check("exfwd_A", fwd_A_sel, 2'b00);

    // Double match, then all-x0
    rd_addr_EX = 7; RegWrite_MEM = 1; rd_addr_MEM = 7; rs1_addr_ID = 7;
    cycle();
    check("dbl_fwd_A", fwd_A_sel, 2'b01);
    rd_addr_EX = 0; rd_addr_MEM = 0; rs1_addr_ID = 0; rs2_addr_ID = 0;
    cycle();
    check("x0_fwd_A", fwd_A_sel, 2'b00);
    idle();

    // Taken branch coinciding with a load-use hit
    RegWrite_EX = 1; MemRead_EX = 1; rd_addr_EX = 5; rs1_addr_ID = 5; rs1_used_ID = 1;
    Branch_EX = 1; zero_out_EX = 1;
    #1 check("taken_ctrl", {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                            IF_ID_flush, ID_EX_flush, PC_sel}, 8'hFF);
    cycle();
    idle();

    // Memory wait: set fwd_A to 01 first, then 3 cycles of wait
    RegWrite_EX = 1; rd_addr_EX = 3; rs1_addr_ID = 3;
    cycle();
    check("pre_wait_fwd_A", fwd_A_sel, 2'b01);
    RegWrite_EX = 0; rd_addr_EX = 0; MemRead_MEM = 1; mem_ready = 0;
`ifdef PERF_CNT_EN
    stall_before = stall_cycles;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      #1 check("wait_ctrl", {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}, 5'b00000);
      cycle();
      check("wait_fwd_hold", fwd_A_sel, 2'b01);
    end
    mem_ready = 1;
    #1 check("wait_release", {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en}, 5'b11111);
`ifdef PERF_CNT_EN
    check("wait_stall_cnt", stall_cycles - stall_before, 32'd3);
`endif
    cycle();
    idle();

    // Reset asserted in the middle of a memory wait
    RegWrite_EX = 1; rd_addr_EX = 4; rs2_addr_ID = 4;
    cycle();
    RegWrite_EX = 0; MemRead_MEM = 1; mem_ready = 0;
    cycle();
    #2 rst_n = 0;
    model_reset();
    #1 check("rstwait_fwd_B", fwd_B_sel, 2'b00);
    check("rstwait_pc_en", PC_en, 1'b0);
    check_outputs();
    @(posedge clk); #1 rst_n = 1;
    idle();
    cycle();

    // Randomized traffic with small register numbers to provoke matches
    for (int unsigned n = 0; n < 600; n++) begin
      rs1_addr_ID  = AW'($urandom_range(0, 3));
      rs2_addr_ID  = AW'($urandom_range(0, 3));
      rd_addr_EX   = AW'($urandom_range(0, 3));
      rd_addr_MEM  = AW'($urandom_range(0, 3));
      rs1_used_ID  = 1'($urandom_range(0, 1));
      rs2_used_ID  = 1'($urandom_range(0, 1));
      RegWrite_EX  = ($urandom_range(0, 3) != 0);
      MemRead_EX   = ($urandom_range(0, 2) == 0);
      RegWrite_MEM = ($urandom_range(0, 3) != 0);
      MemRead_MEM  = ($urandom_range(0, 3) == 0);
      MemWrite_MEM = ($urandom_range(0, 5) == 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      Branch_EX    = ($urandom_range(0, 4) == 0);
      zero_out_EX  = 1'($urandom_range(0, 1));
      Jump_EX      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
